// File: rtl/dec_exe_latch_if.sv
// dec_exe_latch_if: DEC-side inputs and EXE-side outputs of the DEC/EXE pipeline register.
interface dec_exe_latch_if #(parameter int DW = 32, parameter int CW = 16);
  logic          Stall;
  logic          Flush;
  logic          DecValid;
  logic [0:5]    OpCode;
  logic [0:5]    Function;
  logic [0:5]    Rd;
  logic [0:5]    Rs1;
  logic [0:5]    Rs2;
  logic [0:1]    Src1;
  logic [0:1]    Src2;
  logic [0:DW-1] RegRs1Data;
  logic [0:DW-1] RegRs2Data;
  logic [0:DW-1] MEMFwdData;
  logic [0:DW-1] WBFwdData;
  logic [0:DW-1] Imm;
  logic [0:DW-1] PC;
  logic [0:DW-1] EXEOpA;
  logic [0:DW-1] EXEOpB;
  logic [0:DW-1] EXEImm;
  logic [0:DW-1] EXEPC;
  logic [0:5]    EXEOpCode;
  logic [0:5]    EXEFunction;
  logic [0:5]    EXERd;
  logic          EXEValid;
  logic          HazardStall;
  logic          DecHold;
  logic [0:CW-1] BubbleCount;
  modport master (
    output Stall, Flush, DecValid, OpCode, Function, Rd, Rs1, Rs2, Src1, Src2,
           RegRs1Data, RegRs2Data, MEMFwdData, WBFwdData, Imm, PC,
    input  EXEOpA, EXEOpB, EXEImm, EXEPC, EXEOpCode, EXEFunction, EXERd, EXEValid,
           HazardStall, DecHold, BubbleCount
  );
  modport slave (
    input  Stall, Flush, DecValid, OpCode, Function, Rd, Rs1, Rs2, Src1, Src2,
           RegRs1Data, RegRs2Data, MEMFwdData, WBFwdData, Imm, PC,
    output EXEOpA, EXEOpB, EXEImm, EXEPC, EXEOpCode, EXEFunction, EXERd, EXEValid,
           HazardStall, DecHold, BubbleCount
  );
endinterface

// File: rtl/dec_exe_latch.sv
// dec_exe_latch: DEC/EXE pipeline register with operand forwarding mux, load-use bubble insertion and bubble counter.
module dec_exe_latch #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input logic            Clock,
  input logic            nReset,
  dec_exe_latch_if.slave bus
);
  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [DW-1:0] pc;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic [5:0]    rd;
    logic          v;
  } exe_t;
  localparam exe_t BUBBLE = '{a: '0, b: '0, imm: '0, pc: '0, op: 6'h00, fn: 6'h15, rd: '0, v: 1'b0};
  exe_t ex_q, ex_d, cap;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] op_a, op_b;
  logic          load, hazard;
  // Select 01 is reserved and falls through to the register file.
  assign op_a = bus.Src1 == 2'b10 ? bus.MEMFwdData : bus.Src1 == 2'b11 ? bus.WBFwdData : bus.RegRs1Data;
  assign op_b = bus.Src2 == 2'b10 ? bus.MEMFwdData : bus.Src2 == 2'b11 ? bus.WBFwdData : bus.RegRs2Data;
  assign load = ex_q.op >= 6'h20 && ex_q.op <= 6'h25;
  assign hazard = ex_q.v & load & bus.DecValid & (ex_q.rd != '0) &
                  ((ex_q.rd == bus.Rs1) | (ex_q.rd == bus.Rs2));
  assign cap = bus.DecValid ? '{a: op_a, b: op_b, imm: bus.Imm, pc: bus.PC, op: bus.OpCode,
                                fn: bus.Function, rd: bus.Rd, v: 1'b1} : BUBBLE;
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.Flush) ex_d = BUBBLE;
    else if (!bus.Stall) begin
      ex_d  = hazard ? BUBBLE : cap;
      cnt_d = hazard && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ex_q  <= BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.EXEOpA      = ex_q.a;
  assign bus.EXEOpB      = ex_q.b;
  assign bus.EXEImm      = ex_q.imm;
  assign bus.EXEPC       = ex_q.pc;
  assign bus.EXEOpCode   = ex_q.op;
  assign bus.EXEFunction = ex_q.fn;
  assign bus.EXERd       = ex_q.rd;
  assign bus.EXEValid    = ex_q.v;
  assign bus.HazardStall = hazard;
  assign bus.DecHold     = bus.Stall | hazard;
  assign bus.BubbleCount = cnt_q;
endmodule
